// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: bus-cycle phase encodings and PC width.
// The phase order matches the nibble-serial bus: three address, two memory, three execute.
package fetch_unit_pkg;

  localparam int PC_WIDTH = 12;

  typedef enum logic [2:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_t;

  // X3 rolls over into A1 through natural 3-bit wrap.
  function automatic phase_t next_phase(input phase_t ph);
    return phase_t'(ph + 3'd1);
  endfunction

endpackage

// File: rtl/fetch_unit_call_stack.sv
// Circular return-address stack; overflow overwrites the oldest entry and
// underflow simply wraps the pointer, with no error indication.
module call_stack
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic [PC_WIDTH-1:0] push_data,
  output logic [PC_WIDTH-1:0] pop_data
);

  localparam int SP_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_LAST = SP_W'(DEPTH - 1);

  logic [PC_WIDTH-1:0] entries [DEPTH];
  logic [SP_W-1:0]     sp;
  logic [SP_W-1:0]     sp_inc;
  logic [SP_W-1:0]     sp_dec;

  // pop_data is the entry a pop would land on, so the PC can load it in the same edge.
  always_comb begin
    sp_inc   = (sp == SP_LAST) ? '0 : sp + 1'b1;
    sp_dec   = (sp == '0) ? SP_LAST : sp - 1'b1;
    pop_data = entries[sp_dec];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sp <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (pop) begin
      sp <= sp_dec;
    end else if (push) begin
      entries[sp] <= push_data;
      sp          <= sp_inc;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch/sequencing stage: runs the 8-phase nibble bus cycle, latches
// instruction words and steers the program counter from the decoder strobes.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int STACK_DEPTH = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                halt,
  input  logic [3:0]          data_in,
  output logic [3:0]          addr_out,
  output logic                addr_valid,
  output logic                sync,
  output logic [3:0]          inst_opr,
  output logic [3:0]          inst_opa,
  output logic [7:0]          imm,
  output logic                inst_valid,
  output logic                second_word,
  input  logic                two_word,
  input  logic                jump_short,
  input  logic                jump_long,
  input  logic                call,
  input  logic                ret,
  output logic [PC_WIDTH-1:0] pc
);

  phase_t phase;
  phase_t phase_next;

  logic two_word_q;
  logic ret_q;
  logic call_q;
  logic jump_long_q;
  logic jump_short_q;

  logic                pc_update;
  logic                do_push;
  logic                do_pop;
  logic [PC_WIDTH-1:0] pc_plus1;
  logic [PC_WIDTH-1:0] pc_next;
  logic [PC_WIDTH-1:0] stack_top;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) phase <= PH_A1;
    else       phase <= phase_next;
  end

  // Phase sequencing plus the purely phase-decoded bus outputs.
  always_comb begin
    phase_next = phase;
    addr_out   = '0;
    addr_valid = 1'b0;
    sync       = 1'b0;
    inst_valid = 1'b0;
    if (!halt) phase_next = next_phase(phase);
    case (phase)
      PH_A1: begin addr_out = pc[3:0];  addr_valid = 1'b1; end
      PH_A2: begin addr_out = pc[7:4];  addr_valid = 1'b1; end
      PH_A3: begin addr_out = pc[11:8]; addr_valid = 1'b1; end
      PH_X1: inst_valid = 1'b1;
      PH_X3: sync = 1'b1;
      default: ;
    endcase
  end

  // Strobes were already gated by second_word when they were registered in X1.
  always_comb begin
    pc_update = !halt && (phase == PH_X3);
    do_pop    = pc_update && ret_q;
    do_push   = pc_update && call_q && !ret_q;
    pc_plus1  = pc + 1'b1;
    if (ret_q)                      pc_next = stack_top;
    else if (call_q || jump_long_q) pc_next = {inst_opa, imm};
    else if (jump_short_q)          pc_next = {pc[11:8], imm};
    else                            pc_next = pc_plus1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc           <= '0;
      inst_opr     <= '0;
      inst_opa     <= '0;
      imm          <= '0;
      second_word  <= 1'b0;
      two_word_q   <= 1'b0;
      ret_q        <= 1'b0;
      call_q       <= 1'b0;
      jump_long_q  <= 1'b0;
      jump_short_q <= 1'b0;
    end else if (!halt) begin
      case (phase)
        PH_M1: begin
          if (second_word) imm[7:4] <= data_in;
          else             inst_opr <= data_in;
        end
        PH_M2: begin
          if (second_word) imm[3:0] <= data_in;
          else             inst_opa <= data_in;
        end
        PH_X1: begin
          two_word_q   <= two_word && !second_word;
          ret_q        <= ret && !second_word;
          call_q       <= call && second_word;
          jump_long_q  <= jump_long && second_word;
          jump_short_q <= jump_short && second_word;
        end
        PH_X3: begin
          pc          <= pc_next;
          second_word <= two_word_q;
        end
        default: ;
      endcase
    end
  end

  call_stack #(
    .DEPTH (STACK_DEPTH)
  ) u_call_stack (
    .clock     (clock),
    .reset     (reset),
    .push      (do_push),
    .pop       (do_pop),
    .push_data (pc_plus1),
    .pop_data  (stack_top)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small ROM model answers the nibble bus while
// one initial block walks through fetch, jumps, calls/returns, halt and reset.
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic        halt;
  logic [3:0]  data_in;
  logic [3:0]  addr_out;
  logic        addr_valid;
  logic        sync;
  logic [3:0]  inst_opr;
  logic [3:0]  inst_opa;
  logic [7:0]  imm;
  logic        inst_valid;
  logic        second_word;
  logic        two_word;
  logic        jump_short;
  logic        jump_long;
  logic        call;
  logic        ret;
  logic [11:0] pc;

  int assertions = 0;
  int failures   = 0;

  logic [7:0]  rom [4096];
  logic [2:0]  tb_phase;
  logic [11:0] rom_addr;

  logic [11:0] fetch_addr;
  logic        sw_seen;
  logic [3:0]  opr_seen;
  logic [3:0]  opa_seen;
  logic [7:0]  imm_seen;
  logic        iv_seen;

  fetch_unit #(.STACK_DEPTH(3)) dut (
    .clock       (clock),
    .reset       (reset),
    .halt        (halt),
    .data_in     (data_in),
    .addr_out    (addr_out),
    .addr_valid  (addr_valid),
    .sync        (sync),
    .inst_opr    (inst_opr),
    .inst_opa    (inst_opa),
    .imm         (imm),
    .inst_valid  (inst_valid),
    .second_word (second_word),
    .two_word    (two_word),
    .jump_short  (jump_short),
    .jump_long   (jump_long),
    .call        (call),
    .ret         (ret),
    .pc          (pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Independent bus-phase tracker so the ROM knows when to listen and when to answer.
  always @(posedge clock or posedge reset) begin
    if (reset)     tb_phase <= 3'd0;
    else if (!halt) tb_phase <= tb_phase + 3'd1;
  end

  always @(negedge clock) begin
    case (tb_phase)
      3'd0: rom_addr[3:0]  = addr_out;
      3'd1: rom_addr[7:4]  = addr_out;
      3'd2: rom_addr[11:8] = addr_out;
      default: ;
    endcase
    if (tb_phase == 3'd3)      data_in = rom[rom_addr][7:4];
    else if (tb_phase == 3'd4) data_in = rom[rom_addr][3:0];
    else                       data_in = 4'h0;
  end

  task automatic checkOutput(input string tag, input logic [11:0] observed, input logic [11:0] expected);
    assertions++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  // Runs one full 8-phase bus cycle starting in A1 with the given decoder strobes.
  task automatic applyStimulus(input logic tw, input logic jl, input logic js,
                               input logic cl, input logic rt);
    two_word   = tw;
    jump_long  = jl;
    jump_short = js;
    call       = cl;
    ret        = rt;
    for (int p = 0; p < 8; p++) begin
      if (p < 3) fetch_addr[p*4 +: 4] = addr_out;
      if (p == 5) begin
        sw_seen  = second_word;
        opr_seen = inst_opr;
        opa_seen = inst_opa;
        imm_seen = imm;
        iv_seen  = inst_valid;
      end
      step();
    end
    two_word   = 1'b0;
    jump_long  = 1'b0;
    jump_short = 1'b0;
    call       = 1'b0;
    ret        = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] exp_addr [16];
    logic [15:0] exp_iv;

    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    rom[12'h002] = 8'h40; rom[12'h003] = 8'hFF;
    rom[12'h0FF] = 8'h40; rom[12'h100] = 8'h12;
    rom[12'h013] = 8'h41; rom[12'h014] = 8'h05;
    rom[12'h105] = 8'h53; rom[12'h106] = 8'h45;
    rom[12'h107] = 8'h40; rom[12'h108] = 8'h77;
    rom[12'h109] = 8'h40; rom[12'h10A] = 8'h10;
    rom[12'h010] = 8'h51; rom[12'h011] = 8'h10;
    rom[12'h110] = 8'h52; rom[12'h111] = 8'h10;
    rom[12'h210] = 8'h53; rom[12'h211] = 8'h10;
    rom[12'h310] = 8'h54; rom[12'h311] = 8'h00;
    rom[12'h312] = 8'h42; rom[12'h313] = 8'hFE;
    rom[12'h2FE] = 8'h1C; rom[12'h2FF] = 8'h80;
    rom[12'h280] = 8'h42; rom[12'h281] = 8'hFE;
    rom[12'h300] = 8'h4F; rom[12'h301] = 8'hFF;

    reset      = 1'b1;
    halt       = 1'b0;
    two_word   = 1'b0;
    jump_long  = 1'b0;
    jump_short = 1'b0;
    call       = 1'b0;
    ret        = 1'b0;
    data_in    = 4'h0;
    rom_addr   = '0;

    @(negedge clock);
    reset = 1'b0;
    #1;

    // Reset state and the first two plain fetch cycles from address 0.
    checkOutput("reset_pc", pc, 12'h000);
    checkOutput("reset_second_word", {11'b0, second_word}, 12'h0);
    checkOutput("reset_imm", {4'h0, imm}, 12'h000);
    for (int i = 0; i < 16; i++) exp_addr[i] = 4'h0;
    exp_addr[8] = 4'h1;
    exp_iv = 16'h2020;
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("seq_addr_out_c%0d", i), {8'h0, addr_out}, {8'h0, exp_addr[i]});
      checkOutput($sformatf("seq_addr_valid_c%0d", i), {11'b0, addr_valid}, {11'b0, (i % 8) < 3});
      checkOutput($sformatf("seq_inst_valid_c%0d", i), {11'b0, inst_valid}, {11'b0, exp_iv[i]});
      checkOutput($sformatf("seq_sync_c%0d", i), {11'b0, sync}, {11'b0, (i % 8) == 7});
      step();
    end
    checkOutput("seq_pc_after_16", pc, 12'h002);

    // JUN 0x0FF, then JUN at 0x0FF with second word 0x12.
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("jun1_pc", pc, 12'h0FF);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("jun2_first_sw", {11'b0, sw_seen}, 12'h0);
    checkOutput("jun2_fetch_addr", fetch_addr, 12'h0FF);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("jun2_second_sw", {11'b0, sw_seen}, 12'h1);
    checkOutput("jun2_imm", {4'h0, imm_seen}, 12'h012);
    checkOutput("jun2_pc", pc, 12'h012);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("jun2_next_fetch", fetch_addr, 12'h012);

    // Call from 0x105 to 0x345 and return to 0x107.
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("to_105_pc", pc, 12'h105);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("call_opr", {8'h0, opr_seen}, 12'h005);
    checkOutput("call_opa", {8'h0, opa_seen}, 12'h003);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("call_second_iv", {11'b0, iv_seen}, 12'h1);
    checkOutput("call_imm", {4'h0, imm_seen}, 12'h045);
    checkOutput("call_opa_held", {8'h0, opa_seen}, 12'h003);
    checkOutput("call_pc", pc, 12'h345);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("ret_pc", pc, 12'h107);

    // Gating: jump_long on a first word and ret/two_word on a second word are ignored.
    applyStimulus(1, 1, 1, 1, 0);
    checkOutput("gate_first_pc", pc, 12'h108);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("gate_second_sw", {11'b0, sw_seen}, 12'h1);
    checkOutput("gate_second_pc", pc, 12'h109);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("gate_no_chain_sw", {11'b0, sw_seen}, 12'h0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("to_010_pc", pc, 12'h010);

    // Four nested calls overflow a 3-deep stack; the oldest return address is lost.
    applyStimulus(1, 0, 0, 0, 0); applyStimulus(0, 0, 0, 1, 0);
    checkOutput("nest1_pc", pc, 12'h110);
    applyStimulus(1, 0, 0, 0, 0); applyStimulus(0, 0, 0, 1, 0);
    checkOutput("nest2_pc", pc, 12'h210);
    applyStimulus(1, 0, 0, 0, 0); applyStimulus(0, 0, 0, 1, 0);
    checkOutput("nest3_pc", pc, 12'h310);
    applyStimulus(1, 0, 0, 0, 0); applyStimulus(0, 0, 0, 1, 0);
    checkOutput("nest4_pc", pc, 12'h400);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("unnest1_pc", pc, 12'h312);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("unnest2_pc", pc, 12'h212);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("unnest3_pc", pc, 12'h112);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("underflow_pc", pc, 12'h312);

    // jump_short taken and not taken on the second word at 0x2FF.
    applyStimulus(1, 0, 0, 0, 0); applyStimulus(0, 1, 0, 0, 0);
    checkOutput("to_2fe_pc", pc, 12'h2FE);
    applyStimulus(1, 0, 0, 0, 0); applyStimulus(0, 0, 1, 0, 0);
    checkOutput("jcn_taken_pc", pc, 12'h280);
    applyStimulus(1, 0, 0, 0, 0); applyStimulus(0, 1, 0, 0, 0);
    checkOutput("back_to_2fe_pc", pc, 12'h2FE);
    applyStimulus(1, 0, 0, 0, 0); applyStimulus(0, 0, 0, 0, 0);
    checkOutput("jcn_not_taken_pc", pc, 12'h300);

    // Halt for five clocks in M1 of the first word at 0x300.
    two_word = 1'b1;
    repeat (3) step();
    halt = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      checkOutput($sformatf("halt_pc_%0d", k), pc, 12'h300);
      checkOutput($sformatf("halt_addr_out_%0d", k), {8'h0, addr_out}, 12'h000);
      checkOutput($sformatf("halt_inst_valid_%0d", k), {11'b0, inst_valid}, 12'h0);
    end
    halt = 1'b0;
    step();
    checkOutput("post_halt_m2_iv", {11'b0, inst_valid}, 12'h0);
    step();
    checkOutput("post_halt_x1_iv", {11'b0, inst_valid}, 12'h1);
    checkOutput("post_halt_opr", {8'h0, inst_opr}, 12'h004);
    checkOutput("post_halt_opa", {8'h0, inst_opa}, 12'h00F);
    repeat (3) step();
    two_word = 1'b0;
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("to_fff_pc", pc, 12'hFFF);

    // PC wraps from 0xFFF to 0x000.
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("wrap_fetch_addr", fetch_addr, 12'hFFF);
    checkOutput("wrap_pc", pc, 12'h000);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("after_wrap_pc", pc, 12'h001);

    // Asynchronous reset asserted in the middle of X2.
    repeat (6) step();
    checkOutput("pre_reset_addr_valid", {11'b0, addr_valid}, 12'h0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_pc", pc, 12'h000);
    checkOutput("async_reset_addr_valid", {11'b0, addr_valid}, 12'h1);
    checkOutput("async_reset_addr_out", {8'h0, addr_out}, 12'h000);
    checkOutput("async_reset_inst_valid", {11'b0, inst_valid}, 12'h0);
    checkOutput("async_reset_sync", {11'b0, sync}, 12'h0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("post_reset_fetch", fetch_addr, 12'h000);
    checkOutput("post_reset_pc", pc, 12'h001);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch and sequencing stage that sits directly upstream of the datapath.
- Runs the 8-phase nibble-serial bus cycle: A1, A2, A3, M1, M2, X1, X2, X3.
- Drives the 12-bit program counter out on the 4-bit bus, latches opcode/operand nibbles into inst_opr/inst_opa, and handles two-word instructions.
- Updates the PC from take_branch, jump, call and return strobes, using an internal STACK_DEPTH-entry return stack.

Parameters:
STACK_DEPTH, 3, number of return-address entries; must be >= 1.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
halt  in  1  freezes all state while high
data_in  in  4  bus nibble from ROM
addr_out  out  4  bus nibble to ROM (PC slice)
addr_valid  out  1  high during A1..A3
sync  out  1  high during X3
inst_opr  out  4  upper opcode nibble of the current instruction's first word
inst_opa  out  4  lower nibble of the first word; feeds the datapath's inst_operand
imm  out  8  second word {M1 nibble, M2 nibble}
inst_valid  out  1  one-cycle pulse in X1
second_word  out  1  high while the current cycle is a second-word fetch
two_word  in  1  decoder: first word needs a second word (sampled X1)
jump_short  in  1  in-page jump, already qualified by take_branch or reg_is_zero (sampled X1 of second word)
jump_long  in  1  12-bit jump (sampled X1 of second word)
call  in  1  jump_long plus push (sampled X1 of second word)
ret  in  1  pop return address (sampled X1, single-word)
pc  out  12  current program counter (debug)

Behaviour:
- Phase counter: 3 bits, advances by one per clock when halt=0, wraps X3->A1. When halt=1 nothing changes (phase, pc, stack, latches); outputs hold.
- Reset (async, any phase):
  - phase=A1, pc=0, all stack entries=0, sp=0.
  - inst_opr=inst_opa=0, imm=0, second_word=0.
  - inst_valid=0, sync=0, addr_out=0, addr_valid=1.
- Address output: addr_out = pc[3:0] in A1, pc[7:4] in A2, pc[11:8] in A3; 0 in all other phases. addr_valid=1 only in A1..A3.
- Nibble capture:
  - First word: data_in is registered at the M1 edge into inst_opr and at the M2 edge into inst_opa.
  - Second-word cycle: the captures go to imm[7:4] and imm[3:0]; inst_opr and inst_opa hold the first word.
  - Latched values are valid from X1 until the next M1.
- inst_valid is high for exactly one clock in X1, for both first- and second-word cycles. Control strobes are sampled at the X1 edge and registered; the PC update is applied at the X3->A1 edge.
- PC update at end of X3, with this priority:
  1. ret: sp=(sp-1) mod STACK_DEPTH; pc=stack[new sp].
  2. call: stack[sp]=pc+1; sp=(sp+1) mod STACK_DEPTH; pc={inst_opa, imm}.
  3. jump_long: pc={inst_opa, imm}.
  4. jump_short: pc={pc[11:8], imm}, where pc is the address of the second word.
  5. Otherwise: pc=pc+1 mod 4096, so 0xFFF wraps to 0x000.
- Strobe gating: jump_short, jump_long and call are ignored unless second_word=1. ret is ignored when second_word=1.
- two_word handling: if two_word is sampled during a first-word X1, second_word is set for the next cycle and clears at the end of that cycle's X3. two_word is ignored during a second-word cycle.
- Stack boundaries:
  - Overflow wraps and silently overwrites the oldest entry.
  - Underflow wraps and returns whatever entry sp lands on. No error flag.
- sync=1 only in X3.
- Only this block drives the PC; the datapath consumes inst_opa and issues jump_short via the decoder.

Decomposition:
- Shared header cpu_phases.vh, included the same way as the datapath's header: phase encodings PH_A1=0 .. PH_X3=7, plus PC_WIDTH=12.
- One sub-module, call_stack: STACK_DEPTH entries of 12 bits, sp, push/pop ports and a top-of-stack read. Async reset clears all entries.

Test Plan:
- Reset then run 16 clocks with ROM[0]=0x00 and ROM[1]=0x00 -> addr_out sequence 0,0,0 then 1,0,0. inst_valid pulses at cycles 5 and 13. pc=2 after clock 16.
- ROM word at 0x0FF = 0x40 (JUN) with second word 0x12 (two_word, then jump_long) -> second_word=1 on the second fetch, imm=0x12, next A1..A3 drive 2,1,0 (pc=0x012).
- call at pc=0x105 (first-word opa=0x3, imm=0x45), ret executed later -> after the call pc=0x345 and the stack top holds 0x107; after ret pc=0x107.
- Four nested calls from pc 0x010, 0x110, 0x210, 0x310 with STACK_DEPTH=3, then three rets -> returns go to 0x312, 0x212, 0x112 (0x012 was overwritten).
- jump_short on a second word at 0x2FF with imm=0x80 -> pc=0x280; the same instruction with the strobe low -> pc=0x300.
- halt held for 5 clocks mid-M1, then reset asserted mid-X2 -> during halt phase, pc and addr_out are unchanged; on reset, phase=A1 and pc=0 immediately without a clock edge, and inst_valid=0.
